// File: rtl/datapath_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | datapath_seq_pkg: shared types and constants for datapath_sequencer |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

package datapath_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  localparam int INSTR_W = 9;
  localparam int ALU_HI  = 8;
  localparam int ALU_LO  = 6;
  localparam int A1_HI   = 5;
  localparam int A1_LO   = 4;
  localparam int A2_HI   = 3;
  localparam int A2_LO   = 2;
  localparam int A3_HI   = 1;
  localparam int A3_LO   = 0;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

endpackage

`default_nettype wire

// File: rtl/datapath_sequencer_if.sv
// +--------------------------------------------------------------------+
// | datapath_seq_if: program/control bus of datapath_sequencer         |
// | Optional capture signals exist only with SEQ_CAPTURE_EN            |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

interface datapath_seq_if
  import datapath_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic               prog_we;
  logic [AW-1:0]      prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [AW:0]        prog_len;
  logic               start;
  logic               busy;
  logic               done;
  logic [2:0]         alucontrol;
  logic [1:0]         addr1;
  logic [1:0]         addr2;
  logic [1:0]         addr3;
  logic               wr;
`ifdef SEQ_CAPTURE_EN
  logic [31:0]        result;
  logic [31:0]        last_result;
  logic               zero_flag;
`endif

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start,
`ifdef SEQ_CAPTURE_EN
    output result,
    input  last_result, zero_flag,
`endif
    input  busy, done, alucontrol, addr1, addr2, addr3, wr
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start,
`ifdef SEQ_CAPTURE_EN
    input  result,
    output last_result, zero_flag,
`endif
    output busy, done, alucontrol, addr1, addr2, addr3, wr
  );

endinterface

`default_nettype wire

// File: rtl/datapath_sequencer_prog_mem.sv
// +--------------------------------------------------------------------+
// | seq_prog_mem: DEPTH x 9 program store, sync write, async read      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module seq_prog_mem
  import datapath_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic               clk,
  input  wire logic               i_we,
  input  wire logic               i_busy,
  input  wire logic [AW-1:0]      i_waddr,
  input  wire logic [INSTR_W-1:0] i_wdata,
  input  wire logic [AW-1:0]      i_raddr,
  output logic      [INSTR_W-1:0] o_rdata
);

  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic               w_we;

  // The program survives reset, so the array has no reset branch.
  assign w_we = i_we && !i_busy;

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/datapath_sequencer.sv
// +--------------------------------------------------------------------+
// | datapath_sequencer: steps a micro-program into the datapath block  |
// | Optional macro: SEQ_CAPTURE_EN (captures ALU result on WRITE)      |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module datapath_sequencer
  import datapath_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input wire logic      clk,
  input wire logic      rst,
  datapath_seq_if.slave bus
);

  seq_state_t         r_state;
  seq_state_t         w_state_next;
  logic [AW-1:0]      r_pc;
  logic [AW-1:0]      w_pc_next;
  logic [AW:0]        r_len;
  logic [AW:0]        w_len_next;
  logic [AW:0]        w_len_sat;
  logic               w_last;
  logic [INSTR_W-1:0] w_mem_rdata;
  logic [INSTR_W-1:0] r_instr;
  logic               r_busy;
  logic               r_done;
  logic               r_wr;

  seq_prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (bus.prog_we),
    .i_busy  (r_busy),
    .i_waddr (bus.prog_addr),
    .i_wdata (bus.prog_data),
    .i_raddr (w_pc_next),
    .o_rdata (w_mem_rdata)
  );

  assign w_len_sat = (bus.prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.prog_len;
  assign w_last    = ({1'b0, r_pc} == (r_len - 1'b1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_len   <= w_len_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_len_next   = r_len;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.prog_len != '0) begin
            w_len_next   = w_len_sat;
            w_pc_next    = '0;
            w_state_next = SETUP;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      SETUP: w_state_next = WRITE;
      WRITE: begin
        if (w_last) begin
          w_state_next = DONE;
        end else begin
          w_pc_next    = r_pc + 1'b1;
          w_state_next = SETUP;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wr    <= 1'b0;
      r_instr <= '0;
    end else begin
      r_busy <= (w_state_next == SETUP) || (w_state_next == WRITE);
      r_done <= (w_state_next == DONE);
      r_wr   <= (w_state_next == WRITE);
      if (w_state_next == SETUP) begin
        r_instr <= w_mem_rdata;
      end
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.wr         = r_wr;
  assign bus.alucontrol = r_instr[ALU_HI:ALU_LO];
  assign bus.addr1      = r_instr[A1_HI:A1_LO];
  assign bus.addr2      = r_instr[A2_HI:A2_LO];
  assign bus.addr3      = r_instr[A3_HI:A3_LO];

`ifdef SEQ_CAPTURE_EN
  logic [31:0] r_last_result;
  logic        r_zero_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_result <= '0;
      r_zero_flag   <= 1'b0;
    end else if (r_state == WRITE) begin
      r_last_result <= bus.result;
      r_zero_flag   <= (bus.result == 32'd0);
    end
  end

  assign bus.last_result = r_last_result;
  assign bus.zero_flag   = r_zero_flag;
`endif

endmodule

`default_nettype wire

// File: tb/tb_datapath_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_datapath_sequencer: directed self-checking bench                |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_datapath_sequencer;
  import datapath_seq_pkg::*;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [8:0] exp_mem [DEPTH];

  datapath_seq_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  datapath_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_slot(input int slot, input logic [8:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = AW'(slot);
    bus.prog_data = data;
    exp_mem[slot] = data;
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  function automatic logic [31:0] fields();
    return 32'({bus.alucontrol, bus.addr1, bus.addr2, bus.addr3});
  endfunction

  // Starts a run and checks every cycle through DONE and the IDLE after it.
  task automatic run_check(input int len_in, input int n, input bit inject);
    int idx;
    int wr_cnt;
    int busy_cnt;
    wr_cnt   = 0;
    busy_cnt = 0;
    bus.prog_len = (AW+1)'(len_in);
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 2*n+1; c++) begin
      if (inject && c == 3) begin
        bus.start     = 1'b1;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 3'd1;
        bus.prog_data = 9'h1FF;
      end else if (inject && c == 4) begin
        bus.start   = 1'b0;
        bus.prog_we = 1'b0;
      end
      @(negedge clk);
      wr_cnt   += int'(bus.wr);
      busy_cnt += int'(bus.busy);
      if (c <= 2*n) begin
        idx = (c - 1) / 2;
        check_eq("run_busy", 32'(bus.busy), 32'd1);
        check_eq("run_wr", 32'(bus.wr), 32'((c % 2) == 0));
        check_eq("run_done_low", 32'(bus.done), 32'd0);
        check_eq("run_fields", fields(), 32'(exp_mem[idx]));
      end else begin
        check_eq("end_done", 32'(bus.done), 32'd1);
        check_eq("end_busy", 32'(bus.busy), 32'd0);
        check_eq("end_wr", 32'(bus.wr), 32'd0);
      end
    end
    check_eq("wr_pulses", 32'(wr_cnt), 32'(n));
    check_eq("busy_cycles", 32'(busy_cnt), 32'(2*n));
    @(negedge clk);
    check_eq("idle_done", 32'(bus.done), 32'd0);
    check_eq("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
`ifdef SEQ_CAPTURE_EN
    bus.result    = 32'h1234_5678;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_wr", 32'(bus.wr), 32'd0);
    check_eq("rst_fields", fields(), 32'd0);
`ifdef SEQ_CAPTURE_EN
    check_eq("rst_last_result", bus.last_result, 32'd0);
    check_eq("rst_zero_flag", 32'(bus.zero_flag), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Single instruction {001,00,00,01}
    load_slot(0, {ALU_SUB, 2'b00, 2'b00, 2'b01});
    bus.prog_len = 4'd1;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check_eq("single_setup_alu", 32'(bus.alucontrol), 32'd1);
    check_eq("single_setup_addr3", 32'(bus.addr3), 32'd1);
    check_eq("single_setup_wr", 32'(bus.wr), 32'd0);
    @(negedge clk);
    check_eq("single_write_wr", 32'(bus.wr), 32'd1);
    @(negedge clk);
    check_eq("single_done", 32'(bus.done), 32'd1);
    @(negedge clk);
    check_eq("single_done_pulse", 32'(bus.done), 32'd0);

    // Four-instruction program
    load_slot(1, {ALU_SUB, 2'b01, 2'b11, 2'b00});
    load_slot(2, {ALU_ADD, 2'b01, 2'b00, 2'b10});
    load_slot(3, {ALU_SUB, 2'b00, 2'b00, 2'b11});
    check_eq("slot1_value", 32'(exp_mem[1]), 32'h05C);
    run_check(4, 4, 1'b0);

    // Reset during the first WRITE; outputs clear immediately
    bus.prog_len = 4'd4;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_wr", 32'(bus.wr), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("midrst_wr", 32'(bus.wr), 32'd0);
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_done", 32'(bus.done), 32'd0);
    check_eq("midrst_fields", fields(), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_check(4, 4, 1'b0);

    // Zero-length run
    run_check(0, 0, 1'b0);

    // start and prog_we while busy are both ignored
    run_check(4, 4, 1'b1);
    run_check(4, 4, 1'b0);

    // Full depth and saturated length; pc must not wrap
    load_slot(4, 9'h1A5);
    load_slot(5, 9'h0F0);
    load_slot(6, 9'h10F);
    load_slot(7, 9'h1FF);
    run_check(8, 8, 1'b0);
    run_check(15, 8, 1'b0);

    // start in DONE is dropped; start in the following IDLE is accepted
    bus.prog_len = 4'd1;
    bus.start    = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("b2b_done", 32'(bus.done), 32'd1);
    bus.start = 1'b1;
    @(negedge clk);
    check_eq("b2b_ignored_busy", 32'(bus.busy), 32'd0);
    check_eq("b2b_ignored_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("b2b_accepted", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_eq("b2b_write", 32'(bus.wr), 32'd1);
    @(negedge clk);
    check_eq("b2b_done2", 32'(bus.done), 32'd1);
    @(negedge clk);

`ifdef SEQ_CAPTURE_EN
    bus.result = 32'd0;
    run_check(1, 1, 1'b0);
    check_eq("cap_zero_result", bus.last_result, 32'd0);
    check_eq("cap_zero_flag", 32'(bus.zero_flag), 32'd1);
    bus.result = 32'hFFFF_FFFF;
    run_check(1, 1, 1'b0);
    check_eq("cap_ones_result", bus.last_result, 32'hFFFF_FFFF);
    check_eq("cap_ones_flag", 32'(bus.zero_flag), 32'd0);
    bus.result = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("cap_hold_result", bus.last_result, 32'hFFFF_FFFF);
    check_eq("cap_hold_flag", 32'(bus.zero_flag), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/datapath_sequencer.md
# datapath_sequencer

Micro-instruction sequencer that sits directly upstream of the 4-register/ALU `datapath` block. It holds a short program of 9-bit micro-instructions and, on `start`, drives the datapath's `addr1/addr2/addr3/alucontrol/wr` inputs one instruction at a time. Each instruction takes two cycles: a setup cycle with `wr=0`, then a write cycle with `wr=1`. This replaces hand-sequenced stimulus with a reusable controller.

## Interface
Parameters:
- `DEPTH`, 8: number of program slots (power of two, at least 2).
- `AW`, `$clog2(DEPTH)`: program address width.

Ports:
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `prog_we  in  1`: write strobe for a program slot.
- `prog_addr  in  AW`: slot index.
- `prog_data  in  9`: instruction `{alucontrol[8:6], addr1[5:4], addr2[3:2], addr3[1:0]}`.
- `prog_len  in  AW+1`: number of instructions to run, 0..DEPTH, sampled at start.
- `start  in  1`: run request, sampled only in IDLE.
- `busy  out  1`: high from the first SETUP through the last WRITE.
- `done  out  1`: one-cycle pulse after the run completes.
- `alucontrol  out  3`: to datapath.
- `addr1  out  2`: to datapath.
- `addr2  out  2`: to datapath.
- `addr3  out  2`: to datapath.
- `wr  out  1`: to datapath.
- `result  in  32`: datapath ALU result; used only with `SEQ_CAPTURE_EN`.

## Operation
- FSM states: IDLE, SETUP, WRITE, DONE.
- **IDLE**
  - `start=1` and `prog_len>0`: latch `prog_len`, set `pc=0`, go to SETUP.
  - `start=1` and `prog_len=0`: go to DONE; `wr` never asserts.
- **SETUP**: drive the fields of `mem[pc]`, `wr=0`; go to WRITE.
- **WRITE**
  - Fields held, `wr=1`.
  - If `pc==len-1`, go to DONE.
  - Otherwise `pc<=pc+1` and go to SETUP.
- **DONE**: `done=1` for one cycle; go to IDLE.
- **Output values**
  - All outputs are registered.
  - Address/ALU fields hold their last values in IDLE and DONE.
  - `wr` is 1 only in WRITE.
- **Program memory**
  - Written by `prog_we` in any state except SETUP/WRITE; writes while `busy` are ignored.
  - Read combinationally by `pc`.
- **Boundary conditions**
  - `start` while `busy` or in DONE: ignored; no queuing.
  - `prog_len>DEPTH`: saturates to DEPTH.
  - `pc` never wraps within a run.
- **Reset** (any time, including mid-run): state IDLE, `pc=0`, `busy=0`, `done=0`, `wr=0`, `alucontrol=0`, `addr1=addr2=addr3=0`, capture registers 0. Program memory is not cleared.

## Timing
- `start` sampled at edge k: SETUP occupies cycle k+1, WRITE cycle k+2.
- The datapath writes on the edge that ends WRITE.
- Instruction i (0-based) has `wr=1` in cycle k+2+2i.
- For length N: `done` is high in cycle k+2N+1, and `busy` is low from that cycle.
- `prog_len=0`: `done` in cycle k+1.
- Back-to-back runs: the earliest accepted `start` is in the IDLE cycle after DONE.

## Configuration
- **`SEQ_CAPTURE_EN` defined**: adds outputs `last_result[31:0]` and `zero_flag`.
  - In every WRITE cycle, `last_result<=result` and `zero_flag<=(result==0)`.
  - Both reset to 0 and hold outside WRITE.
- **Undefined**: these ports and registers do not exist, and `result` is unconnected.

## Structure
- Package `datapath_seq_pkg`:
  - state enum (IDLE=0, SETUP=1, WRITE=2, DONE=3);
  - instruction field bit positions;
  - ALU opcode constants `ALU_ADD=3'b000`, `ALU_SUB=3'b001`.
- Sub-module `seq_prog_mem`: DEPTH×9 register array with synchronous write, asynchronous read, and a write-enable gated by `!busy`.

## Test plan
- **Reset mid-run**: assert `rst=0` during a WRITE cycle → `wr`, `busy`, `done` and all fields read 0 immediately; state is IDLE; the program is intact, and re-`start` replays from slot 0.
- **Single instruction**: load slot 0 = {001,00,00,01}, `prog_len=1`, pulse `start` → one SETUP with `alucontrol=1`, `addr3=1`, `wr=0`; one WRITE with `wr=1`; `done` high exactly 3 cycles after the `start` edge.
- **Four-instruction program driving a real `datapath`**: {001,00,00,01}, {001,01,11,00}, {000,01,00,10}, {001,00,00,11} → exactly 4 `wr` pulses 2 cycles apart; `busy` high for 8 cycles.
- **`prog_len=0`**: `done` in the next cycle, `wr` never asserts; `prog_len=DEPTH+... `saturation check: `prog_len`=DEPTH → slot DEPTH-1 is executed and `pc` does not wrap.
- **Ignored inputs**: `start` pulsed while `busy` and `prog_we` pulsed while `busy` → neither the run length nor the memory contents change.
- **`SEQ_CAPTURE_EN` build**: drive `result=0` then `result=32'hFFFF_FFFF` on successive WRITEs → `zero_flag` goes 1 then 0, and `last_result` tracks `result`.
